// File: rtl/text_writer_pkg.sv
// Shared text-mode definitions: screen geometry defaults, control codes and
// writer states, used by the writer, the pixel-side generator and the VRAM.
package text_writer_pkg;

  localparam int unsigned DEF_COLS     = 80;
  localparam int unsigned DEF_ROWS     = 60;
  localparam logic [7:0]  DEF_CLR_CHAR = 8'h20;

  localparam logic [7:0] CHR_BS = 8'h08;
  localparam logic [7:0] CHR_LF = 8'h0A;
  localparam logic [7:0] CHR_FF = 8'h0C;
  localparam logic [7:0] CHR_CR = 8'h0D;

  localparam logic [7:0] CHR_FIRST_PRINTABLE = 8'h20;

  typedef enum logic [1:0] {
    CLR_SCREEN,
    CLR_LINE,
    IDLE
  } state_t;

endpackage

// File: rtl/text_writer.sv
// Character-stream writer: accepts bytes, tracks the cursor, and writes
// character ordinals or clear fills into the text VRAM, one cell per cycle.
module text_writer
  import text_writer_pkg::*;
#(
  parameter  int unsigned COLS     = DEF_COLS,
  parameter  int unsigned ROWS     = DEF_ROWS,
  parameter  logic [7:0]  CLR_CHAR = DEF_CLR_CHAR,
  localparam int unsigned ADDR_W   = $clog2(COLS * ROWS),
  localparam int unsigned CW       = $clog2(COLS),
  localparam int unsigned RW       = $clog2(ROWS)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [7:0]        chr_i,
  input  logic              chr_valid_i,
  output logic              chr_ready_o,
  output logic              vram_we_o,
  output logic [ADDR_W-1:0] vram_addr_o,
  output logic [7:0]        vram_data_o,
  output logic [CW-1:0]     cursor_col_o,
  output logic [RW-1:0]     cursor_row_o
);

  localparam logic [CW-1:0]     LAST_COL   = CW'(COLS - 1);
  localparam logic [RW-1:0]     LAST_ROW   = RW'(ROWS - 1);
  localparam logic [ADDR_W-1:0] LAST_CELL  = ADDR_W'(COLS * ROWS - 1);
  localparam logic [ADDR_W-1:0] LAST_COL_A = ADDR_W'(COLS - 1);
  localparam logic [ADDR_W-1:0] COLS_A     = ADDR_W'(COLS);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic [CW-1:0]       col_q, col_d;
  logic [RW-1:0]       row_q, row_d;
  logic [ADDR_W-1:0]   row_base_q, row_base_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          data_q, data_d;

  logic                row_wrap;
  logic [RW-1:0]       nxt_row;
  logic [ADDR_W-1:0]   nxt_base;

  // Row advance is circular; row_base tracks row*COLS by addition only.
  assign row_wrap = (row_q == LAST_ROW);
  assign nxt_row  = row_wrap ? '0 : row_q + RW'(1);
  assign nxt_base = row_wrap ? '0 : row_base_q + COLS_A;

  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    col_d      = col_q;
    row_d      = row_q;
    row_base_d = row_base_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;

    unique case (state_q)
      CLR_SCREEN: begin
        we_d   = 1'b1;
        addr_d = clr_cnt_q;
        data_d = CLR_CHAR;
        if (clr_cnt_q == LAST_CELL) begin
          state_d   = IDLE;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        end
      end

      CLR_LINE: begin
        we_d   = 1'b1;
        addr_d = row_base_q + clr_cnt_q;
        data_d = CLR_CHAR;
        if (clr_cnt_q == LAST_COL_A) begin
          state_d   = IDLE;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        end
      end

      IDLE: begin
        if (chr_valid_i) begin
          if (chr_i >= CHR_FIRST_PRINTABLE) begin
            we_d   = 1'b1;
            addr_d = row_base_q + ADDR_W'(col_q);
            data_d = chr_i;
            if (col_q == LAST_COL) begin
              col_d      = '0;
              row_d      = nxt_row;
              row_base_d = nxt_base;
              clr_cnt_d  = '0;
              state_d    = CLR_LINE;
            end else begin
              col_d = col_q + CW'(1);
            end
          end else begin
            case (chr_i)
              CHR_LF: begin
                row_d      = nxt_row;
                row_base_d = nxt_base;
                clr_cnt_d  = '0;
                state_d    = CLR_LINE;
              end
              CHR_CR: col_d = '0;
              CHR_BS: begin
                if (col_q != '0) col_d = col_q - CW'(1);
              end
              CHR_FF: begin
                col_d      = '0;
                row_d      = '0;
                row_base_d = '0;
                clr_cnt_d  = '0;
                state_d    = CLR_SCREEN;
              end
              default: ;
            endcase
          end
        end
      end

      default: begin
        state_d   = CLR_SCREEN;
        clr_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= CLR_SCREEN;
      clr_cnt_q  <= '0;
      col_q      <= '0;
      row_q      <= '0;
      row_base_q <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      col_q      <= col_d;
      row_q      <= row_d;
      row_base_q <= row_base_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
    end
  end

  assign chr_ready_o  = (state_q == IDLE);
  assign vram_we_o    = we_q;
  assign vram_addr_o  = addr_q;
  assign vram_data_o  = data_q;
  assign cursor_col_o = col_q;
  assign cursor_row_o = row_q;

endmodule

// File: doc/text_writer.md
# text_writer

Character-stream writer for the text-mode VGA path. It consumes 8-bit character codes over a valid/ready handshake, interprets a small set of control codes, and writes character ordinals into the text VRAM at the cursor position. The pixel-side text generator reads those same VRAM cells through the font ROM. It sits between a byte source (UART, CPU port) and the VRAM write port, and handles cursor tracking, auto-wrap, and line/screen clearing.

## Interface
- COLS, default 80: text columns per line
- ROWS, default 60: text lines per screen
- CLR_CHAR, default 8'h20: ordinal written when clearing cells
- Derived: ADDR_W = clog2(COLS*ROWS), CW = clog2(COLS), RW = clog2(ROWS)

- clk_i  in  1  system/pixel clock; single clock domain
- rst_i  in  1  reset, synchronous, active-high
- chr_i  in  8  character code
- chr_valid_i  in  1  chr_i is valid
- chr_ready_o  out  1  writer can accept; transfer on the edge where valid & ready
- vram_we_o  out  1  VRAM write strobe, one write per cycle
- vram_addr_o  out  ADDR_W  cell address, row*COLS + col
- vram_data_o  out  8  character ordinal to store
- cursor_col_o  out  CW  current cursor column
- cursor_row_o  out  RW  current cursor row

## Operation
- States: CLR_SCREEN, CLR_LINE, IDLE. chr_ready_o is high only in IDLE.
- Reset sets state=CLR_SCREEN, clear counter=0, cursor=(0,0), vram_we_o=0, vram_addr_o=0, vram_data_o=0, chr_ready_o=0.
- CLR_SCREEN: writes CLR_CHAR to addresses 0..COLS*ROWS-1, one per cycle, ascending, then goes to IDLE.
- CLR_LINE: writes CLR_CHAR to row_base+0 .. row_base+COLS-1 of the new cursor row, then goes to IDLE.
- Accepted codes in IDLE:
  - 0x20–0xFF, printable: write chr_i at the cursor.
    - If col<COLS-1: col+1, stay in IDLE.
    - If col=COLS-1: col=0, row advances as for LF, go to CLR_LINE.
  - 0x0A LF: col unchanged; row+1, or row=0 when row=ROWS-1 (circular screen, no scroll). Go to CLR_LINE; the destination row is always cleared.
  - 0x0D CR: col=0, no write.
  - 0x08 BS: col-1 if col>0, otherwise no change; no write and no erase.
  - 0x0C FF: cursor=(0,0), go to CLR_SCREEN.
  - Other 0x00–0x1F: consumed and ignored, no write.
- Row addressing uses a row_base register (row*COLS), updated by +COLS, or reset to 0 on wrap. No multiplier.
- An rst_i assertion at any time aborts the current clear and restarts the full-screen clear from address 0.

## Timing
- All outputs are registered. A write registered on edge E is presented in cycle E+1.
- Printable char accepted on edge E: vram_we_o=1 with its address and data in cycle E+1; cursor outputs updated in cycle E+1. Sustained throughput is 1 char/clk within a line.
- Line clear triggered on edge E (LF, or wrap after a char write):
  - chr_ready_o is low from cycle E+1.
  - Clear writes appear in cycles E+2 .. E+COLS+1; for a wrap, the char write occupies cycle E+1.
  - For LF, vram_we_o=0 in cycle E+1.
  - chr_ready_o returns high in cycle E+COLS+1, the same cycle as the final clear write.
  - A char accepted at edge E+COLS+1 writes in cycle E+COLS+2, so there is no overlap.
- Screen clear after reset release (first edge with rst_i low = edge 1): writes appear in cycles 2 .. COLS*ROWS+1; chr_ready_o goes high in cycle COLS*ROWS+1.
- Screen clear after FF follows the same pattern relative to the acceptance edge.
- vram_we_o is never high for more than one address per cycle; addresses never exceed COLS*ROWS-1.

## Structure
- Shared text-mode package holds: control-code constants (CHR_BS, CHR_LF, CHR_FF, CHR_CR), the state enum, and default COLS/ROWS/CLR_CHAR shared with the pixel-side generator and the VRAM instance.
- Single module; no sub-module. The cursor/row_base update is kept as one always block alongside the FSM.

## Test plan
- Reset release (COLS=80, ROWS=60) -> exactly 4800 writes of 0x20 at addresses 0..4799 in order; chr_ready_o rises with the last write; cursor=(0,0).
- Send "AB" back-to-back -> writes (0,0x41), (1,0x42) on consecutive cycles; cursor_col_o=2; chr_ready_o stays high.
- 80 printable chars from col 0 row 0 -> last char written at addr 79, then 80 clears at 80..159; cursor=(0,1); ready low for exactly 80 cycles.
- Cursor row 59, send LF -> cursor row 0; addresses 0..79 cleared; no other writes. Then CR/BS at col 0 -> no writes, col stays 0.
- Send "X", BS, "Y" -> Y overwrites X's address; send 0x07 -> no write, cursor unchanged.
- FF mid-screen, then assert rst_i halfway through the resulting clear -> the clear restarts at address 0 and completes all 4800 writes; the cursor stays (0,0).
